// File: rtl/float_discriminant_pkg.sv
// Shared types and constants for the float_discriminant arg/res protocol.
// The format is IEEE double: sign, NE-bit exponent, then mantissa.
package float_discriminant_pkg;

  localparam int FLEN = 64;
  localparam int NE   = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } req_state_t;

  localparam logic [FLEN-1:0] FLOAT_ERR_RES = '1;

  function automatic logic is_err(input logic [FLEN-1:0] x);
    return &x[FLEN-2 -: NE];
  endfunction

endpackage

// File: rtl/float_discriminant_requester_req_watchdog.sv
// Response watchdog: counts cycles while enabled and flags the cycle on which
// the count reaches TIMEOUT-1. clr has priority and returns the count to zero.
module req_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT);
  // tc fires on the increment that would land on TIMEOUT-1, so the count never wraps
  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 2);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (en) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign tc = en && !clr && (timer_q == TC_VAL);

endmodule

// File: rtl/float_discriminant_requester.sv
// Initiator for the discriminant unit: captures {a,b,c}, issues one arg_vld,
// waits for res_vld (or watchdog expiry) and holds the result until taken.
module float_discriminant_requester
  import float_discriminant_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [FLEN-1:0] in_a,
  input  logic [FLEN-1:0] in_b,
  input  logic [FLEN-1:0] in_c,
  output logic            arg_vld,
  output logic [FLEN-1:0] a,
  output logic [FLEN-1:0] b,
  output logic [FLEN-1:0] c,
  input  logic            busy,
  input  logic            res_vld,
  input  logic [FLEN-1:0] res,
  input  logic            res_negative,
  input  logic            err,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [FLEN-1:0] out_res,
  output logic            out_negative,
  output logic            out_err,
  output logic            out_timeout,
  output logic            stray_err
);

  req_state_t state_q, state_d;

  logic [FLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [FLEN-1:0] res_q, res_d;
  logic            neg_q, neg_d, err_q, err_d, to_q, to_d;
  logic            stray_q, stray_d;
  logic            accept, in_wait, wd_tc;

  req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (!in_wait),
    .en  (in_wait && !res_vld),
    .tc  (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)              state_d = ST_ISSUE;
      ST_ISSUE: if (arg_vld)             state_d = ST_WAIT;
      ST_WAIT:  if (res_vld || wd_tc)    state_d = ST_HOLD;
      ST_HOLD:  if (out_rdy)             state_d = accept ? ST_ISSUE : ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // in_rdy passes out_rdy through in HOLD so a new request can follow back-to-back
  always_comb begin
    in_wait = (state_q == ST_WAIT);
    in_rdy  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_rdy);
    arg_vld = (state_q == ST_ISSUE) && !busy && !rst;
    out_vld = (state_q == ST_HOLD);
    accept  = in_vld && in_rdy;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    neg_d   = neg_q;
    err_d   = err_q;
    to_d    = to_q;
    stray_d = stray_q || (res_vld && !in_wait);
    if (accept) begin
      a_d = in_a;
      b_d = in_b;
      c_d = in_c;
    end
    // a real response on the expiry cycle still wins over the forced error
    if (in_wait && res_vld) begin
      res_d = res;
      neg_d = res_negative;
      err_d = err;
      to_d  = 1'b0;
    end else if (in_wait && wd_tc) begin
      res_d = FLOAT_ERR_RES;
      neg_d = 1'b0;
      err_d = 1'b1;
      to_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      to_q    <= to_d;
      stray_q <= stray_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign c            = c_q;
  assign out_res      = res_q;
  assign out_negative = neg_q;
  assign out_err      = err_q;
  assign out_timeout  = to_q;
  assign stray_err    = stray_q;

endmodule

// File: tb/tb_float_discriminant_requester.sv
// Directed and randomized bench for float_discriminant_requester with a
// behavioural discriminant unit of settable latency, busy and silence.
module tb_float_discriminant_requester;
  import float_discriminant_pkg::*;

  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_vld = 1'b0;
  logic            busy = 1'b0;
  logic            out_rdy = 1'b0;
  logic            force_res = 1'b0;
  logic [63:0]     in_a = '0, in_b = '0, in_c = '0;
  logic            in_rdy, arg_vld, out_vld, out_negative, out_err, out_timeout, stray_err;
  logic [63:0]     a, b, c, out_res;
  logic            res_vld, res_negative, err;
  logic [63:0]     res;

  logic            mdl_vld = 1'b0;
  logic [63:0]     mdl_res = '0;
  bit              pend = 1'b0;
  bit              never = 1'b0;
  int              lat = 1;
  int              cnt = 0;
  int              arg_cnt = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_discriminant_requester #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .busy(busy), .res_vld(res_vld), .res(res), .res_negative(res_negative), .err(err),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .out_negative(out_negative), .out_err(out_err), .out_timeout(out_timeout),
    .stray_err(stray_err)
  );

  function automatic real disc(input logic [63:0] fa, input logic [63:0] fb, input logic [63:0] fc);
    return $bitstoreal(fb) * $bitstoreal(fb) - 4.0 * $bitstoreal(fa) * $bitstoreal(fc);
  endfunction

  // Behavioural discriminant unit: answers lat cycles after arg_vld unless silenced.
  assign res_vld      = mdl_vld | force_res;
  assign res          = mdl_res;
  assign res_negative = mdl_res[63];
  assign err          = is_err(mdl_res);

  always @(posedge clk) begin
    mdl_vld <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (arg_vld) begin
      arg_cnt <= arg_cnt + 1;
      mdl_res <= $realtobits(disc(a, b, c));
      if (!never) begin
        if (lat <= 1) mdl_vld <= 1'b1;
        else begin
          pend <= 1'b1;
          cnt  <= lat - 1;
        end
      end
    end else if (pend) begin
      if (cnt == 1) begin
        mdl_vld <= 1'b1;
        pend    <= 1'b0;
      end
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] sa, input logic [63:0] sb, input logic [63:0] sc);
    int n = 0;
    @(negedge clk);
    in_a = sa; in_b = sb; in_c = sc; in_vld = 1'b1;
    #1;
    while (!in_rdy && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("send_in_rdy", {63'd0, in_rdy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    #1;
    while (!out_vld && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("out_vld_seen", {63'd0, out_vld}, 64'd1);
  endtask

  task automatic chk_res(input string tag, input logic [63:0] er, input logic en, input logic ee, input logic et);
    chk({tag, "_res"}, out_res, er);
    chk({tag, "_neg"}, {63'd0, out_negative}, {63'd0, en});
    chk({tag, "_err"}, {63'd0, out_err}, {63'd0, ee});
    chk({tag, "_timeout"}, {63'd0, out_timeout}, {63'd0, et});
  endtask

  task automatic pop();
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_rdy"}, {63'd0, in_rdy}, 64'd1);
    chk({tag, "_arg_vld"}, {63'd0, arg_vld}, 64'd0);
    chk({tag, "_out_vld"}, {63'd0, out_vld}, 64'd0);
    chk({tag, "_a"}, a, 64'd0);
    chk({tag, "_c"}, c, 64'd0);
    chk({tag, "_stray"}, {63'd0, stray_err}, 64'd0);
    chk_res(tag, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, base;
    logic [63:0] ra, rb, rc, na, nb, nc, er;
    real rv;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("rst_arg_vld", {63'd0, arg_vld}, 64'd0);
    rst = 1'b0;
    #1 chk_reset_state("reset");

    // 1: 1,4,3 -> 4.0
    lat = 4; base = arg_cnt;
    send($realtobits(1.0), $realtobits(4.0), $realtobits(3.0));
    chk("t1_a", a, $realtobits(1.0));
    wait_out(n);
    chk("t1_arg_count", 64'(arg_cnt - base), 64'd1);
    chk_res("t1", $realtobits(4.0), 1'b0, 1'b0, 1'b0);
    pop();

    // 2: 1,2,3 -> -8.0
    lat = 1;
    send($realtobits(1.0), $realtobits(2.0), $realtobits(3.0));
    wait_out(n);
    chk_res("t2", $realtobits(-8.0), 1'b1, 1'b0, 1'b0);
    pop();

    // 3: busy held 5 cycles after accept
    busy = 1'b1; lat = 3; base = arg_cnt;
    send($realtobits(2.0), $realtobits(5.0), $realtobits(1.0));
    #1 chk("t3_busy_c1", {63'd0, arg_vld}, 64'd0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk); #1 chk("t3_busy_cn", {63'd0, arg_vld}, 64'd0);
    end
    @(negedge clk); busy = 1'b0;
    #1 chk("t3_issue_c6", {63'd0, arg_vld}, 64'd1);
    wait_out(n);
    chk("t3_latency", 64'(n), 64'd4);
    chk("t3_arg_count", 64'(arg_cnt - base), 64'd1);
    chk_res("t3", $realtobits(17.0), 1'b0, 1'b0, 1'b0);
    pop();

    // 4: silent unit -> watchdog result, later response is stray
    never = 1'b1;
    send($realtobits(1.0), $realtobits(1.0), $realtobits(1.0));
    #1 chk("t4_issue", {63'd0, arg_vld}, 64'd1);
    n = 0;
    while (!out_vld && n < TO + 20) begin
      @(negedge clk); #1; n++;
    end
    chk("t4_timeout_latency", 64'(n), 64'(TO));
    chk_res("t4", FLOAT_ERR_RES, 1'b0, 1'b1, 1'b1);
    chk("t4_stray_before", {63'd0, stray_err}, 64'd0);
    @(negedge clk); force_res = 1'b1;
    @(negedge clk); force_res = 1'b0;
    #1 chk("t4_stray_after", {63'd0, stray_err}, 64'd1);
    chk("t4_res_kept", out_res, FLOAT_ERR_RES);
    pop();
    never = 1'b0;

    // 5: downstream stall, then back-to-back capture
    lat = 2;
    ra = $realtobits(0.5); rb = $realtobits(3.0); rc = $realtobits(2.0);
    na = $realtobits(-1.5); nb = $realtobits(1.0); nc = $realtobits(4.0);
    send(ra, rb, rc);
    wait_out(n);
    er = $realtobits(disc(ra, rb, rc));
    @(negedge clk);
    in_a = na; in_b = nb; in_c = nc; in_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_hold_vld", {63'd0, out_vld}, 64'd1);
      chk("t5_hold_res", out_res, er);
      chk("t5_hold_in_rdy", {63'd0, in_rdy}, 64'd0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1 chk("t5_release_in_rdy", {63'd0, in_rdy}, 64'd1);
    @(negedge clk);
    out_rdy = 1'b0; in_vld = 1'b0;
    #1 chk("t5_b2b_arg", {63'd0, arg_vld}, 64'd1);
    chk("t5_b2b_a", a, na);
    wait_out(n);
    chk_res("t5b", $realtobits(disc(na, nb, nc)), 1'b0, 1'b0, 1'b0);
    pop();

    // 6: reset during WAIT
    lat = 20;
    send($realtobits(1.0), $realtobits(4.0), $realtobits(3.0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_state("t6_rst");

    for (int t = 0; t < 100; t++) begin
      ra = $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 8.0);
      rb = $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 4.0);
      rc = $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 16.0);
      lat = int'($urandom_range(1, 5));
      rv = disc(ra, rb, rc);
      send(ra, rb, rc);
      wait_out(n);
      chk_res("rand", $realtobits(rv), rv < 0.0, 1'b0, 1'b0);
      pop();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
